// File: rtl/sram_fifo_sync.sv
// Synchronous FIFO on a single-port-write / synchronous-read array, with a
// two-entry registered output stage that hides the one-cycle read latency.
module sram_fifo_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 4
) (
    input  logic                  clk,
    input  logic                  arst_n_in,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0]   cnt_t;
    typedef logic [ADDR_WIDTH-1:0] ptr_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t AF_C    = cnt_t'(AF_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] skid;
    ptr_t                  wr_ptr;
    ptr_t                  rd_ptr;
    cnt_t                  arr_cnt;
    cnt_t                  count_nxt;
    logic                  rd_pend;
    logic                  skid_v;
    logic                  push;
    logic                  pop;
    logic                  rd_issue;
    logic [2:0]            pipe_occ;

    assign din_ready = (count < DEPTH_C);
    assign push      = din_valid && din_ready;
    assign pop       = dout_valid && dout_ready;

    // Words already committed to the output side: head, skid and the read in flight.
    assign pipe_occ  = 3'(dout_valid) + 3'(skid_v) + 3'(rd_pend);
    // arr_cnt excludes the word written this edge, so a read never hits the write address.
    assign rd_issue  = !flush && (arr_cnt != '0) && ((pipe_occ - 3'(pop)) < 3'd2);

    assign count_nxt = count + cnt_t'(push) - cnt_t'(pop);

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
        if (rd_issue)       rd_data     <= mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            arr_cnt     <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            arr_cnt     <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + ptr_t'(push);
            rd_ptr      <= rd_ptr + ptr_t'(rd_issue);
            arr_cnt     <= arr_cnt + cnt_t'(push) - cnt_t'(rd_issue);
            count       <= count_nxt;
            almost_full <= (count_nxt >= AF_C);
        end
    end

    // Head register is dout itself; skid holds the second word when the consumer stalls.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            rd_pend    <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            skid       <= '0;
            skid_v     <= 1'b0;
        end else if (flush) begin
            rd_pend    <= 1'b0;
            dout_valid <= 1'b0;
            skid_v     <= 1'b0;
        end else begin
            rd_pend <= rd_issue;
            if (pop) begin
                if (skid_v) begin
                    dout <= skid;
                    if (rd_pend) skid   <= rd_data;
                    else         skid_v <= 1'b0;
                end else if (rd_pend) begin
                    dout <= rd_data;
                end else begin
                    dout_valid <= 1'b0;
                end
            end else if (rd_pend) begin
                if (!dout_valid) begin
                    dout       <= rd_data;
                    dout_valid <= 1'b1;
                end else begin
                    skid   <= rd_data;
                    skid_v <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_fifo_sync.sv
// Directed bench for sram_fifo_sync: latency, streaming, fill limits, flush,
// asynchronous reset and a long randomised back-pressure run with a scoreboard.
module tb_sram_fifo_sync;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic          clk = 1'b0;
    logic          arst_n_in;
    logic          flush;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [AW:0]   count;
    logic          almost_full;

    int n_cmp = 0;
    int n_err = 0;

    sram_fifo_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF)) dut (
        .clk(clk), .arst_n_in(arst_n_in), .flush(flush),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .count(count), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst_n_in = 1'b0; flush = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
        #12;
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_dout_valid got %b want 0", dout_valid); end
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout got %h want 00", dout); end
        n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_af got %b want 0", almost_full); end
        n_cmp++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL reset_din_ready got %b want 1", din_ready); end
        arst_n_in = 1'b1;
        step();
    endtask

    task automatic test_first_word();
        din = 8'h11; din_valid = 1'b1; dout_ready = 1'b0;
        step();
        din_valid = 1'b0;
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL fw_count_e1 got %0d want 1", count); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL fw_valid_e1 got %b want 0", dout_valid); end
        step();
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL fw_valid_e2 got %b want 0", dout_valid); end
        step();
        n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL fw_valid_e3 got %b want 1", dout_valid); end
        n_cmp++; if (dout !== 8'h11) begin n_err++; $display("FAIL fw_dout_e3 got %h want 11", dout); end
        n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL fw_count_e3 got %0d want 1", count); end
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL fw_count_drain got %0d want 0", count); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL fw_valid_drain got %b want 0", dout_valid); end
    endtask

    // 48 words through a 16-deep FIFO: word k pushed at edge k+1, popped at edge k+4.
    task automatic test_back_to_back();
        int sent = 0;
        int rcvd = 0;
        int cyc  = 0;
        logic p_push, p_pop;
        din = 8'h00; din_valid = 1'b1; dout_ready = 1'b1;
        while (rcvd < 3 * DEPTH && cyc < 500) begin
            p_push = din_valid && din_ready;
            p_pop  = dout_valid && dout_ready;
            if (p_pop) begin
                n_cmp++;
                if (dout !== 8'(rcvd)) begin n_err++; $display("FAIL stream_word got %h want %h", dout, 8'(rcvd)); end
                rcvd++;
            end
            step();
            cyc++;
            if (p_push) begin
                sent++;
                din = 8'(sent);
                if (sent == 3 * DEPTH) din_valid = 1'b0;
            end
        end
        dout_ready = 1'b0;
        n_cmp++; if (rcvd != 3 * DEPTH) begin n_err++; $display("FAIL stream_rcvd got %0d want %0d", rcvd, 3 * DEPTH); end
        n_cmp++; if (cyc != 3 * DEPTH + 3) begin n_err++; $display("FAIL stream_cycles got %0d want %0d", cyc, 3 * DEPTH + 3); end
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL stream_count_end got %0d want 0", count); end
    endtask

    task automatic test_fill();
        int exp_cnt;
        int guard;
        logic [7:0] exp_w;
        dout_ready = 1'b0; din_valid = 1'b1;
        for (int i = 0; i <= DEPTH + 1; i++) begin
            exp_cnt = (i > DEPTH) ? DEPTH : i;
            n_cmp++; if (count !== 5'(exp_cnt)) begin n_err++; $display("FAIL fill_count i=%0d got %0d want %0d", i, count, exp_cnt); end
            n_cmp++; if (almost_full !== (exp_cnt >= AF)) begin n_err++; $display("FAIL fill_af i=%0d got %b want %b", i, almost_full, exp_cnt >= AF); end
            n_cmp++; if (din_ready !== (exp_cnt < DEPTH)) begin n_err++; $display("FAIL fill_din_ready i=%0d got %b want %b", i, din_ready, exp_cnt < DEPTH); end
            din = 8'h40 + 8'(i);
            step();
        end
        din_valid = 1'b0; dout_ready = 1'b1;
        n_cmp++; if (dout !== 8'h40) begin n_err++; $display("FAIL fill_head got %h want 40", dout); end
        step();
        n_cmp++; if (count !== 5'd15) begin n_err++; $display("FAIL fill_pop_count got %0d want 15", count); end
        n_cmp++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL fill_pop_din_ready got %b want 1", din_ready); end
        n_cmp++; if (almost_full !== 1'b1) begin n_err++; $display("FAIL fill_pop_af got %b want 1", almost_full); end
        din = 8'h50; din_valid = 1'b1;
        n_cmp++; if (dout !== 8'h41) begin n_err++; $display("FAIL fill_head2 got %h want 41", dout); end
        step();
        din_valid = 1'b0;
        n_cmp++; if (count !== 5'd15) begin n_err++; $display("FAIL fill_pushpop_count got %0d want 15", count); end
        for (int k = 0; k < 15; k++) begin
            exp_w = (k < 14) ? 8'h42 + 8'(k) : 8'h50;
            guard = 0;
            while (!dout_valid && guard < 20) begin step(); guard++; end
            n_cmp++; if (dout_valid !== 1'b1 || dout !== exp_w) begin n_err++; $display("FAIL fill_drain k=%0d got %h/%b want %h", k, dout, dout_valid, exp_w); end
            step();
        end
        dout_ready = 1'b0;
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL fill_drain_count got %0d want 0", count); end
    endtask

    task automatic test_flush();
        dout_ready = 1'b0; din_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin din = 8'h60 + 8'(i); step(); end
        din_valid = 1'b0; dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        n_cmp++; if (count !== 5'd5) begin n_err++; $display("FAIL flush_pre_count got %0d want 5", count); end
        flush = 1'b1; din_valid = 1'b1; din = 8'hA5;
        step();
        flush = 1'b0; din_valid = 1'b0;
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL flush_count got %0d want 0", count); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", dout_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (dout_valid !== 1'b0 || count !== 5'd0) begin n_err++; $display("FAIL flush_idle got v=%b c=%0d want v=0 c=0", dout_valid, count); end
        end
        din = 8'h77; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        step();
        step();
        n_cmp++; if (dout_valid !== 1'b1 || dout !== 8'h77) begin n_err++; $display("FAIL flush_next_word got %h/%b want 77/1", dout, dout_valid); end
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        dout_ready = 1'b0; din_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin din = 8'h80 + 8'(i); step(); end
        din_valid = 1'b0;
        n_cmp++; if (count !== 5'd7) begin n_err++; $display("FAIL arst_pre_count got %0d want 7", count); end
        #2;
        arst_n_in = 1'b0;
        #1;
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL arst_count got %0d want 0", count); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b want 0", dout_valid); end
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL arst_dout got %h want 00", dout); end
        n_cmp++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL arst_din_ready got %b want 1", din_ready); end
        n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL arst_af got %b want 0", almost_full); end
        #2;
        arst_n_in = 1'b1;
        step();
        din = 8'h99; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        step();
        step();
        n_cmp++; if (dout_valid !== 1'b1 || dout !== 8'h99) begin n_err++; $display("FAIL arst_resume got %h/%b want 99/1", dout, dout_valid); end
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        n_cmp++; if (count !== 5'd0 || dout_valid !== 1'b0) begin n_err++; $display("FAIL arst_stale got c=%0d v=%b want c=0 v=0", count, dout_valid); end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic       stall_prev = 1'b0;
        logic [7:0] dout_prev = '0;
        logic       p_push, p_pop;
        int         wp, rp, guard;
        for (int c = 0; c < 20000; c++) begin
            wp = (c < 10000) ? 70 : 35;
            rp = (c < 10000) ? 35 : 70;
            din_valid  = ($urandom_range(0, 99) < wp);
            dout_ready = ($urandom_range(0, 99) < rp);
            din        = 8'($urandom);
            #1;
            n_cmp++; if (count !== 5'(q.size())) begin n_err++; $display("FAIL rand_count c=%0d got %0d want %0d", c, count, q.size()); end
            if (stall_prev) begin
                n_cmp++; if (dout_valid !== 1'b1 || dout !== dout_prev) begin n_err++; $display("FAIL rand_stall c=%0d got %h/%b want %h/1", c, dout, dout_valid, dout_prev); end
            end
            p_push = din_valid && din_ready;
            p_pop  = dout_valid && dout_ready;
            if (p_pop) begin
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL rand_pop_empty c=%0d got %h want none", c, dout); end
                else begin
                    if (dout !== q[0]) begin n_err++; $display("FAIL rand_data c=%0d got %h want %h", c, dout, q[0]); end
                    void'(q.pop_front());
                end
            end
            if (p_push) q.push_back(din);
            stall_prev = dout_valid && !dout_ready;
            dout_prev  = dout;
            step();
        end
        din_valid = 1'b0; dout_ready = 1'b1; guard = 0;
        while (q.size() != 0 && guard < 200) begin
            if (dout_valid) begin
                n_cmp++; if (dout !== q[0]) begin n_err++; $display("FAIL rand_drain got %h want %h", dout, q[0]); end
                void'(q.pop_front());
            end
            step();
            guard++;
        end
        dout_ready = 1'b0;
        n_cmp++; if (q.size() != 0 || count !== 5'd0) begin n_err++; $display("FAIL rand_drain_end got q=%0d c=%0d want 0/0", q.size(), count); end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_back_to_back();
        test_fill();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
